instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Upstream stage of the control unit. Holds the program counter, instruction MAR and instruction register. Runs a req/ack read handshake to instruction memory and presents the fetched 16-bit instruction word to the control unit. Driven by the control unit's PC, PC-select, I_MAR and fetch strobes.

## Interface
- ADDR_W, 8, PC/MAR/instruction-memory address width
- INSTR_W, 16, instruction word width
- TIMEOUT, 15, max cycles waiting for `imem_ack` before a fetch error
- RESET_PC, 0, PC value after reset
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- pc_load  in  1  PC update strobe (control unit `signal_PC`)
- pc_sel  in  1  0: PC+1; 1: jump to `instruction[ADDR_W-1:0]`
- mar_load  in  1  capture target address into MAR (`signal_I_MAR`)
- fetch_start  in  1  begin memory read at MAR (`signal_read_I_mem`)
- imem_addr  out  ADDR_W  memory address (= MAR)
- imem_req  out  1  read request, held until ack or timeout
- imem_ack  in  1  memory data valid this cycle
- imem_rdata  in  INSTR_W  read data, sampled when `imem_ack` is high
- instruction  out  INSTR_W  IR contents to control unit
- pc  out  ADDR_W  current PC
- busy  out  1  fetch in progress
- fetch_done  out  1  one-cycle pulse: IR updated
- fetch_err  out  1  sticky: timeout occurred; cleared only by reset

## Operation
- Reset values: pc=RESET_PC, MAR=0, instruction=0, imem_req=0, busy=0, fetch_done=0, fetch_err=0, FSM in IDLE.
- PC/MAR update, applied only when not busy:
  - pc_load & mar_load & !pc_sel: MAR<=pc, pc<=pc+1.
  - pc_load & mar_load & pc_sel: MAR<=target, pc<=target+1. Target = instruction[ADDR_W-1:0].
  - pc_load alone: pc updates only.
  - mar_load alone: MAR<=pc.
- PC arithmetic is modulo 2^ADDR_W; 8'hFF+1 wraps to 8'h00.
- FSM states: IDLE, REQ, DONE.
  - IDLE: on fetch_start go to REQ, set imem_req=1, clear timeout counter.
  - REQ: on imem_ack, IR<=imem_rdata, imem_req<=0, go to DONE.
  - REQ: if the counter reaches TIMEOUT with no ack, IR<={OPC_HLT, zeros}, set fetch_err, imem_req<=0, go to DONE.
  - DONE: fetch_done=1 for one cycle, then IDLE.
- busy=1 in REQ and DONE.
- Ignored inputs:
  - fetch_start while busy.
  - pc_load/mar_load while busy; PC and MAR are unchanged.
  - imem_ack outside REQ; IR is unchanged.
- Ack and timeout in the same cycle: ack wins. Data is loaded and fetch_err is not set.
- Reset mid-fetch: immediately returns to IDLE with reset values; a late ack is ignored.
- Combinational paths: imem_addr and pc are direct register outputs; no input-to-output path.

## Timing
- Latency: fetch_start sampled at edge N gives imem_req high from N+1.
- Ack sampled at edge M gives instruction valid and fetch_done high in cycle M+1, and busy low from M+2.
- Zero-wait memory (ack in the first REQ cycle) gives 3 cycles from fetch_start to the next accepted fetch_start.
- Timeout: imem_req stays high for exactly TIMEOUT cycles, then drops.
- fetch_done, fetch_err and busy are registered.

## Structure
- Shared package cpu_pkg:
  - opcode constants, including OPC_HLT (same encoding as the control unit's instruction set)
  - fetch FSM state encoding (IDLE/REQ/DONE)
  - ADDR_W/INSTR_W defaults
- Sub-module program_counter holds the PC register, increment/jump mux and MAR capture. The fetch FSM, timeout counter and IR stay in the top.

## Test plan
- Sequential fetch: reset, then pc_load+mar_load (pc_sel=0) three times, each followed by fetch_start with zero-wait ack returning 16'h0801/16'h0802/16'h0803. Expect imem_addr 0,1,2, instruction matching each word, and pc=3.
- Jump: IR=16'hXX42 and pc_sel=1 with pc_load+mar_load. Expect MAR=8'h42 and pc=8'h43. A jump target of 8'hFF gives pc=8'h00.
- Wait states: ack after 5 cycles with data 16'hBEEF. Expect imem_req high 5 cycles, fetch_done one cycle later, and instruction=16'hBEEF.
- Timeout: never ack. Expect imem_req low after 15 cycles, instruction={OPC_HLT,11'b0}, fetch_err=1 held until reset.
- Busy guards: pulse pc_load and fetch_start during REQ. Expect pc/MAR unchanged and no second request. A spurious ack in IDLE leaves IR unchanged.
- Reset mid-fetch: assert reset in REQ cycle 2, then ack in the next cycle. Expect all outputs at reset values and IR=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: widths, opcodes, fetch FSM encoding
package cpu_pkg;

  // Default datapath widths
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  // Opcode field occupies the top OPC_W bits of an instruction word
  localparam int OPC_W = 5;
  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OPC_NOP = 5'h00;
  localparam opcode_t OPC_LDA = 5'h01;
  localparam opcode_t OPC_STA = 5'h02;
  localparam opcode_t OPC_ADD = 5'h03;
  localparam opcode_t OPC_SUB = 5'h04;
  localparam opcode_t OPC_AND = 5'h05;
  localparam opcode_t OPC_OR  = 5'h06;
  localparam opcode_t OPC_XOR = 5'h07;
  localparam opcode_t OPC_JMP = 5'h08;
  localparam opcode_t OPC_JZ  = 5'h09;
  localparam opcode_t OPC_JNZ = 5'h0A;
  localparam opcode_t OPC_HLT = 5'h1F;

  // Fetch FSM state encoding
  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_REQ  = 2'd1;
  localparam logic [1:0] FETCH_DONE = 2'd2;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with increment/jump mux and MAR capture
module program_counter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pc_load,
  input  logic              pc_sel,
  input  logic              mar_load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mar
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] base_addr;

  // A jump fetches from the target; a sequential step fetches from the current PC
  always_comb begin
    base_addr = pc_sel ? target : pc_q;
  end

  // PC and MAR only move while the fetch engine is idle; increment wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= ADDR_W'(RESET_PC);
      mar_q <= '0;
    end else if (enable) begin
      if (pc_load) begin
        pc_q <= base_addr + 1'b1;
      end
      if (mar_load) begin
        mar_q <= pc_load ? base_addr : pc_q;
      end
    end
  end

  assign pc  = pc_q;
  assign mar = mar_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC/MAR/IR holder running the instruction memory read handshake
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int TIMEOUT  = 15,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_load,
  input  logic               pc_sel,
  input  logic               mar_load,
  input  logic               fetch_start,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               fetch_done,
  output logic               fetch_err
);

  // Counter holds the number of REQ cycles already spent without an ack
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [INSTR_W-1:0] HLT_WORD = {OPC_HLT, {(INSTR_W - OPC_W){1'b0}}};

  logic [1:0]         state;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [INSTR_W-1:0] ir_q;
  logic               req_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clk      (clk),
    .reset    (reset),
    .enable   (~busy_q),
    .pc_load  (pc_load),
    .pc_sel   (pc_sel),
    .mar_load (mar_load),
    .target   (ir_q[ADDR_W-1:0]),
    .pc       (pc),
    .mar      (imem_addr)
  );

  // Fetch FSM: request, wait for ack or timeout, pulse done, return to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH_IDLE;
      tmo_cnt <= '0;
      ir_q    <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (fetch_start) begin
            state   <= FETCH_REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        FETCH_REQ: begin
          // Ack is checked first so a last-cycle ack beats the timeout
          if (imem_ack) begin
            ir_q   <= imem_rdata;
            req_q  <= 1'b0;
            done_q <= 1'b1;
            state  <= FETCH_DONE;
          end else if (tmo_cnt == CNT_LAST) begin
            ir_q   <= HLT_WORD;
            err_q  <= 1'b1;
            req_q  <= 1'b0;
            done_q <= 1'b1;
            state  <= FETCH_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FETCH_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= FETCH_IDLE;
        end
        default: begin
          req_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= FETCH_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign instruction = ir_q;
  assign busy        = busy_q;
  assign fetch_done  = done_q;
  assign fetch_err   = err_q;

endmodule
